cpu_mem_responder: RTL and testbench

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

---
 rtl/cpu_mem_responder.sv | 126 ++++++++++++
 tb/tb_cpu_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Byte-addressed 16-bit-word memory shared by a CPU port and a halted-only host port.
// Big-endian lanes; the array is zero-filled one word per cycle after every reset.
module cpu_mem_responder #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] mem_raddr,
  input  logic [addr_width-1:0] mem_waddr,
  input  logic                  mem_write,
  input  logic [7:0]            mem_data_in,
  output logic [7:0]            mem_data_out,
  output logic                  mem_ready,
  input  logic                  cpu_halted,
  input  logic [addr_width-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  input  logic                  host_re,
  input  logic                  host_we,
  output logic [7:0]            host_rdata,
  output logic                  host_valid
);

  localparam int AW    = addr_width - 1;
  localparam int WORDS = 1 << AW;

  localparam logic [2:0] CLEAR    = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] HOST_RD  = 3'd2;
  localparam logic [2:0] HOST_RD2 = 3'd3;
  localparam logic [2:0] HOST_WR  = 3'd4;

  logic [15:0]           mem_q [WORDS];
  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [addr_width-1:0] haddr_q, haddr_d;
  logic [7:0]            hwdata_q, hwdata_d;
  logic [7:0]            dout_q, dout_d;
  logic [7:0]            hrdata_q, hrdata_d;

  function automatic logic [7:0] pick(
    input logic [15:0] w,
    input logic        lo
  );
    return lo ? w[7:0] : w[15:8];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hrdata_d = hrdata_q;
    // write-first: a same-address write is returned instead of the old byte
    if (mem_write && (mem_waddr == mem_raddr))
      dout_d = mem_data_in;
    else
      dout_d = pick(mem_q[mem_raddr[AW:1]], mem_raddr[0]);
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1)
          state_d = RUN;
      end
      RUN: begin
        if (cpu_halted && (host_we || host_re)) begin
          haddr_d  = host_addr;
          hwdata_d = host_wdata;
          state_d  = host_we ? HOST_WR : HOST_RD;
        end
      end
      HOST_RD: begin
        hrdata_d = pick(mem_q[haddr_q[AW:1]], haddr_q[0]);
        state_d  = HOST_RD2;
      end
      HOST_RD2: state_d = RUN;
      HOST_WR:  state_d = RUN;
      default:  state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      dout_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      dout_q   <= dout_d;
      hrdata_q <= hrdata_d;
    end
  end

  // host byte is written first so a same-edge CPU write to that byte wins
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= 16'h0000;
      end else begin
        if (state_q == HOST_WR) begin
          if (haddr_q[0])
            mem_q[haddr_q[AW:1]][7:0] <= hwdata_q;
          else
            mem_q[haddr_q[AW:1]][15:8] <= hwdata_q;
        end
        if (mem_write) begin
          if (mem_waddr[0])
            mem_q[mem_waddr[AW:1]][7:0] <= mem_data_in;
          else
            mem_q[mem_waddr[AW:1]][15:8] <= mem_data_in;
        end
      end
    end
  end

  assign mem_data_out = dout_q;
  assign host_rdata   = hrdata_q;
  assign mem_ready    = (state_q == RUN);
  assign host_valid   = (state_q == HOST_RD2) || (state_q == HOST_WR);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: vector table, corner sequences and
// randomized CPU/host traffic against a flat byte-array model.
module tb_cpu_mem_responder;

  localparam int AWD = 9;
  localparam int NB  = 1 << AWD;

  logic           clk = 1'b0;
  logic           reset;
  logic [AWD-1:0] mem_raddr, mem_waddr;
  logic           mem_write;
  logic [7:0]     mem_data_in;
  logic [7:0]     mem_data_out;
  logic           mem_ready;
  logic           cpu_halted;
  logic [AWD-1:0] host_addr;
  logic [7:0]     host_wdata;
  logic           host_re, host_we;
  logic [7:0]     host_rdata;
  logic           host_valid;

  always #5 clk = ~clk;

  cpu_mem_responder #(.addr_width(AWD)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_raddr    (mem_raddr),
    .mem_waddr    (mem_waddr),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready),
    .cpu_halted   (cpu_halted),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_re      (host_re),
    .host_we      (host_we),
    .host_rdata   (host_rdata),
    .host_valid   (host_valid)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mm [NB];

  typedef struct {
    logic           we;
    logic [AWD-1:0] wa;
    logic [7:0]     wd;
    logic [AWD-1:0] ra;
    logic [7:0]     exp;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < NB; i++) mm[i] = 8'h00;
  endtask

  task automatic wait_ready(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (mem_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
      if (host_valid !== 1'b0) saw_valid = 1'b1;
    end
  endtask

  task automatic cpu_step(input logic we, input logic [AWD-1:0] wa,
                          input logic [7:0] wd, input logic [AWD-1:0] ra,
                          output logic [7:0] exp);
    exp = (we && wa == ra) ? wd : mm[ra];
    mem_write   = we;
    mem_waddr   = wa;
    mem_data_in = wd;
    mem_raddr   = ra;
    tick();
    if (we) mm[wa] = wd;
    mem_write = 1'b0;
  endtask

  task automatic host_write(input logic [AWD-1:0] a, input logic [7:0] d);
    cpu_halted = 1'b1;
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we = 1'b0;
    chk("hw_valid", host_valid, 1'b1);
    chk("hw_busy", mem_ready, 1'b0);
    tick();
    mm[a] = d;
    chk("hw_valid_end", host_valid, 1'b0);
    chk("hw_ready_back", mem_ready, 1'b1);
    cpu_halted = 1'b0;
  endtask

  task automatic host_read(input logic [AWD-1:0] a);
    cpu_halted = 1'b1;
    host_re    = 1'b1;
    host_addr  = a;
    tick();
    host_re = 1'b0;
    chk("hr_valid_early", host_valid, 1'b0);
    chk("hr_busy1", mem_ready, 1'b0);
    tick();
    chk("hr_valid", host_valid, 1'b1);
    chk("hr_data", host_rdata, mm[a]);
    chk("hr_busy2", mem_ready, 1'b0);
    tick();
    chk("hr_valid_end", host_valid, 1'b0);
    chk("hr_hold", host_rdata, mm[a]);
    chk("hr_ready_back", mem_ready, 1'b1);
    cpu_halted = 1'b0;
  endtask

  initial begin
    int n;
    bit sv;
    logic [7:0] e;

    reset = 1'b0;
    mem_raddr = '0; mem_waddr = '0; mem_write = 1'b0; mem_data_in = '0;
    cpu_halted = 1'b0; host_addr = '0; host_wdata = '0;
    host_re = 1'b0; host_we = 1'b0;
    model_clear();

    tick();
    tick();
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_dout", mem_data_out, 8'h00);
    chk("rst_hrdata", host_rdata, 8'h00);
    chk("rst_hvalid", host_valid, 1'b0);

    reset = 1'b1;
    wait_ready(n, sv);
    chk("clear_cycles", n, 256);
    chk("clear_no_valid", sv, 1'b0);

    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd300, 8'h00});
    tv.push_back('{1'b1, 9'd4,   8'hAB, 9'd0,   8'h00});
    tv.push_back('{1'b1, 9'd5,   8'hCD, 9'd4,   8'hAB});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd5,   8'hCD});
    tv.push_back('{1'b1, 9'd7,   8'h5A, 9'd7,   8'h5A});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd7,   8'h5A});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd6,   8'h00});
    tv.push_back('{1'b1, 9'd6,   8'h77, 9'd7,   8'h5A});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd6,   8'h77});
    tv.push_back('{1'b1, 9'd511, 8'hEE, 9'd511, 8'hEE});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd510, 8'h00});
    tv.push_back('{1'b1, 9'd4,   8'h12, 9'd5,   8'hCD});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd4,   8'h12});
    tv.push_back('{1'b0, 9'd0,   8'h00, 9'd511, 8'hEE});

    foreach (tv[i]) begin
      cpu_step(tv[i].we, tv[i].wa, tv[i].wd, tv[i].ra, e);
      chk($sformatf("vec%0d_dout", i), mem_data_out, tv[i].exp);
      chk($sformatf("vec%0d_ready", i), mem_ready, 1'b1);
    end

    host_write(9'd10, 8'h3C);
    host_read(9'd10);
    chk("host_rd_3c", host_rdata, 8'h3C);

    cpu_halted = 1'b0;
    host_re = 1'b1;
    host_addr = 9'd10;
    tick();
    host_re = 1'b0;
    chk("drop_valid", host_valid, 1'b0);
    chk("drop_ready", mem_ready, 1'b1);
    tick();
    chk("drop_valid2", host_valid, 1'b0);
    chk("drop_ready2", mem_ready, 1'b1);

    cpu_halted = 1'b1;
    host_we = 1'b1;
    host_addr = 9'd3;
    host_wdata = 8'h22;
    tick();
    host_we = 1'b0;
    cpu_halted = 1'b0;
    chk("coll_valid", host_valid, 1'b1);
    mem_write = 1'b1;
    mem_waddr = 9'd3;
    mem_data_in = 8'h11;
    tick();
    mem_write = 1'b0;
    mm[3] = 8'h11;
    cpu_step(1'b0, 9'd0, 8'h00, 9'd3, e);
    chk("coll_cpu_wins", mem_data_out, 8'h11);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        host_write(AWD'($urandom_range(0, NB - 1)), 8'($urandom));
      end else if (r == 1) begin
        host_read(AWD'($urandom_range(0, NB - 1)));
      end else begin
        logic we;
        logic [AWD-1:0] wa, ra;
        we = 1'($urandom);
        wa = AWD'($urandom_range(0, NB - 1));
        ra = ($urandom_range(0, 3) == 0) ? wa : AWD'($urandom_range(0, NB - 1));
        host_re = 1'($urandom);
        host_we = 1'($urandom);
        host_addr = AWD'($urandom);
        cpu_step(we, wa, 8'($urandom), ra, e);
        host_re = 1'b0;
        host_we = 1'b0;
        chk("rnd_dout", mem_data_out, e);
        chk("rnd_no_valid", host_valid, 1'b0);
        chk("rnd_ready", mem_ready, 1'b1);
      end
    end

    cpu_step(1'b1, 9'd4, 8'h9C, 9'd0, e);
    cpu_halted = 1'b1;
    host_re = 1'b1;
    host_addr = 9'd4;
    tick();
    host_re = 1'b0;
    chk("abort_in_rd", mem_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("abort_valid", host_valid, 1'b0);
    chk("abort_ready", mem_ready, 1'b0);
    chk("abort_dout", mem_data_out, 8'h00);
    reset = 1'b1;
    host_re = 1'b1;
    wait_ready(n, sv);
    host_re = 1'b0;
    cpu_halted = 1'b0;
    model_clear();
    chk("reclear_cycles", n, 256);
    chk("reclear_no_valid", sv, 1'b0);
    tick();
    chk("reclear_no_accept", mem_ready, 1'b1);
    cpu_step(1'b0, 9'd0, 8'h00, 9'd4, e);
    chk("reclear_rd4", mem_data_out, 8'h00);
    cpu_step(1'b0, 9'd0, 8'h00, 9'd3, e);
    chk("reclear_rd3", mem_data_out, 8'h00);
    cpu_step(1'b0, 9'd0, 8'h00, 9'd10, e);
    chk("reclear_rd10", mem_data_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
